// File: rtl/dct_zigzag_buf.sv
// dct_zigzag_buf: two-bank 8x8 coefficient buffer. Raster-order writes in, JPEG zigzag valid/ready stream out.
// Optional macro DCT_ZZ_DC_DIFF_EN: the DC beat carries the difference from the previous block's DC.
`timescale 1ns/1ps

// state  | meaning
// IDLE   | no block on the output; wait for full[rd_bank]
// STREAM | out_data holds element k-1 of rd_bank; advance on accept
module dct_zigzag_buf #(
    parameter int cw = 12,
    parameter int aw = 6
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          init_n,
    input  logic          dct_wr_n,
    input  logic [aw-1:0] dct_wr_add,
    input  logic [cw-1:0] dct_wr_data,
    input  logic          dct_done,
    output logic          blk_rdy,
    output logic [cw-1:0] out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          out_first,
    output logic          out_last,
    output logic          ovf
);
    localparam int NC = 1 << aw;

    localparam logic [5:0] ZZ [64] = '{
        6'd0,  6'd1,  6'd8,  6'd16, 6'd9,  6'd2,  6'd3,  6'd10,
        6'd17, 6'd24, 6'd32, 6'd25, 6'd18, 6'd11, 6'd4,  6'd5,
        6'd12, 6'd19, 6'd26, 6'd33, 6'd40, 6'd48, 6'd41, 6'd34,
        6'd27, 6'd20, 6'd13, 6'd6,  6'd7,  6'd14, 6'd21, 6'd28,
        6'd35, 6'd42, 6'd49, 6'd56, 6'd57, 6'd50, 6'd43, 6'd36,
        6'd29, 6'd22, 6'd15, 6'd23, 6'd30, 6'd37, 6'd44, 6'd51,
        6'd58, 6'd59, 6'd52, 6'd45, 6'd38, 6'd31, 6'd39, 6'd46,
        6'd53, 6'd60, 6'd61, 6'd54, 6'd47, 6'd55, 6'd62, 6'd63
    };

    typedef enum logic {IDLE = 1'b0, STREAM = 1'b1} state_t;

    logic [cw-1:0] mem [2][NC];

    state_t        state_q, state_d;
    logic          wr_bank_q, wr_bank_d;
    logic          rd_bank_q, rd_bank_d;
    logic [1:0]    full_q, full_d;
    logic [aw-1:0] k_q, k_d;
    logic [cw-1:0] data_q, data_d;
    logic          valid_q, valid_d;
    logic          first_q, first_d;
    logic          last_q, last_d;
    logic          ovf_q, ovf_d;

    logic          wr_full, wr_en, done_en, accept;
    logic [cw-1:0] rd_elem, rd_dc, dc_out;

    assign wr_full = full_q[wr_bank_q];
    assign wr_en   = ~dct_wr_n & ~wr_full;
    assign done_en = dct_done & ~wr_full;
    assign accept  = valid_q & out_ready;
    assign rd_elem = mem[rd_bank_q][ZZ[k_q]];
    assign rd_dc   = mem[rd_bank_q][ZZ[0]];

`ifdef DCT_ZZ_DC_DIFF_EN
    logic [cw-1:0] prev_dc_q, prev_dc_d;

    // The raw DC is still in the bank while element 0 is being accepted.
    assign dc_out = rd_dc - prev_dc_q;

    always_comb begin
        prev_dc_d = prev_dc_q;
        if (accept && first_q) begin
            prev_dc_d = rd_dc;
        end
        if (!init_n) begin
            prev_dc_d = '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev_dc_q <= '0;
        end else begin
            prev_dc_q <= prev_dc_d;
        end
    end
`else
    assign dc_out = rd_dc;
`endif

    // Coefficient storage is never cleared; a write shares the edge with a closing done.
    always_ff @(posedge clk) begin
        if (wr_en && init_n) begin
            mem[wr_bank_q][dct_wr_add] <= dct_wr_data;
        end
    end

    always_comb begin
        state_d   = state_q;
        wr_bank_d = wr_bank_q;
        rd_bank_d = rd_bank_q;
        full_d    = full_q;
        k_d       = k_q;
        data_d    = data_q;
        valid_d   = valid_q;
        first_d   = first_q;
        last_d    = last_q;
        ovf_d     = ovf_q | (wr_full & (~dct_wr_n | dct_done));

        case (state_q)
            IDLE: begin
                if (full_q[rd_bank_q]) begin
                    data_d  = dc_out;
                    valid_d = 1'b1;
                    first_d = 1'b1;
                    last_d  = 1'b0;
                    k_d     = aw'(1);
                    state_d = STREAM;
                end
            end
            STREAM: begin
                if (accept) begin
                    first_d = 1'b0;
                    if (!last_q) begin
                        data_d = rd_elem;
                        k_d    = k_q + aw'(1);
                        last_d = (k_q == aw'(NC - 1));
                    end else begin
                        valid_d           = 1'b0;
                        last_d            = 1'b0;
                        full_d[rd_bank_q] = 1'b0;
                        rd_bank_d         = ~rd_bank_q;
                        k_d               = '0;
                        state_d           = IDLE;
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // Reader clears rd_bank, writer sets wr_bank; the two are never the same bank here.
        if (done_en) begin
            full_d[wr_bank_q] = 1'b1;
            wr_bank_d         = ~wr_bank_q;
        end

        if (!init_n) begin
            state_d   = IDLE;
            wr_bank_d = 1'b0;
            rd_bank_d = 1'b0;
            full_d    = '0;
            k_d       = '0;
            data_d    = '0;
            valid_d   = 1'b0;
            first_d   = 1'b0;
            last_d    = 1'b0;
            ovf_d     = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            wr_bank_q <= 1'b0;
            rd_bank_q <= 1'b0;
            full_q    <= '0;
            k_q       <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            first_q   <= 1'b0;
            last_q    <= 1'b0;
            ovf_q     <= 1'b0;
        end else begin
            state_q   <= state_d;
            wr_bank_q <= wr_bank_d;
            rd_bank_q <= rd_bank_d;
            full_q    <= full_d;
            k_q       <= k_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            first_q   <= first_d;
            last_q    <= last_d;
            ovf_q     <= ovf_d;
        end
    end

    assign blk_rdy   = ~wr_full;
    assign out_data  = data_q;
    assign out_valid = valid_q;
    assign out_first = first_q;
    assign out_last  = last_q;
    assign ovf       = ovf_q;

endmodule

// File: tb/tb_dct_zigzag_buf.sv
// Bench for dct_zigzag_buf: scoreboard of zigzag-ordered beats, pushed at block commit, popped on accept.
// Build with +define+DCT_ZZ_DC_DIFF_EN to exercise the DC difference option.
`timescale 1ns/1ps

module tb_dct_zigzag_buf;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        init_n = 1'b1;
    logic        dct_wr_n = 1'b1;
    logic [5:0]  dct_wr_add = '0;
    logic [11:0] dct_wr_data = '0;
    logic        dct_done = 1'b0;
    logic        blk_rdy;
    logic [11:0] out_data;
    logic        out_valid;
    logic        out_ready = 1'b0;
    logic        out_first;
    logic        out_last;
    logic        ovf;

    dct_zigzag_buf #(.cw(12), .aw(6)) dut (
        .clk(clk), .rst_n(rst_n), .init_n(init_n),
        .dct_wr_n(dct_wr_n), .dct_wr_add(dct_wr_add), .dct_wr_data(dct_wr_data),
        .dct_done(dct_done), .blk_rdy(blk_rdy),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .out_first(out_first), .out_last(out_last), .ovf(ovf)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [11:0] d;
        logic        f;
        logic        l;
    } ent_t;

    ent_t        sb [$];
    int          total = 0;
    int          bad = 0;
    int          beats = 0;
    int          rdy_mode = 0;   // 0 low, 1 high, 2 random, 3 manual
    int          zz [64];
    logic [11:0] cur_blk [64];
    logic [11:0] prev_model = '0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s obs=%0h exp=%0h t=%0t", tag, obs, exp, $time);
        end
    endtask

    // Zigzag built independently by walking the anti-diagonals.
    initial begin
        int n;
        n = 0;
        for (int s = 0; s < 15; s++) begin
            if (s % 2 == 0) begin
                for (int r = (s < 8 ? s : 7); r >= (s > 7 ? s - 7 : 0); r--) begin
                    zz[n] = r * 8 + (s - r);
                    n++;
                end
            end else begin
                for (int r = (s > 7 ? s - 7 : 0); r <= (s < 8 ? s : 7); r++) begin
                    zz[n] = r * 8 + (s - r);
                    n++;
                end
            end
        end
    end

    initial begin
        forever begin
            @(posedge clk);
            #1;
            case (rdy_mode)
                0: out_ready = 1'b0;
                1: out_ready = 1'b1;
                2: out_ready = 1'($urandom_range(0, 1));
                default: ;
            endcase
        end
    end

    initial begin
        ent_t e;
        forever begin
            @(negedge clk);
            if (rst_n && out_valid) begin
                if (sb.size() == 0) begin
                    chk("unexpected_beat", sb.size(), 1);
                end else begin
                    e = sb[0];
                    chk("data", out_data, e.d);
                    chk("first", out_first, e.f);
                    chk("last", out_last, e.l);
                    if (out_ready) begin
                        void'(sb.pop_front());
                        beats++;
                    end
                end
            end
        end
    end

    task automatic push_block();
        ent_t e;
        for (int j = 0; j < 64; j++) begin
            e.d = cur_blk[zz[j]];
            e.f = (j == 0);
            e.l = (j == 63);
            if (j == 0) begin
`ifdef DCT_ZZ_DC_DIFF_EN
                e.d = cur_blk[0] - prev_model;
                prev_model = cur_blk[0];
`endif
            end
            sb.push_back(e);
        end
    endtask

    task automatic write_block(input int salt, input logic [11:0] dcv, input bit addr_pat,
                               input bit done_last, input bit do_done, input bit expect_ok);
        for (int a = 0; a < 64; a++) begin
            cur_blk[a] = addr_pat ? 12'(a) : 12'(a * 37 + salt);
        end
        if (!addr_pat) cur_blk[0] = dcv;
        for (int a = 0; a < 64; a++) begin
            @(posedge clk);
            #1;
            dct_wr_n    = 1'b0;
            dct_wr_add  = 6'(a);
            dct_wr_data = cur_blk[a];
            dct_done    = do_done && done_last && (a == 63);
        end
        if (expect_ok && do_done) push_block();
        @(posedge clk);
        #1;
        dct_wr_n = 1'b1;
        dct_done = 1'b0;
        if (do_done && !done_last) begin
            dct_done = 1'b1;
            @(posedge clk);
            #1;
            dct_done = 1'b0;
        end
    endtask

    task automatic wait_drain(input string tag);
        int n;
        n = 0;
        while (sb.size() != 0 && n < 2000) begin
            @(negedge clk);
            n++;
        end
        chk(tag, sb.size(), 0);
        repeat (3) @(negedge clk);
    endtask

    initial begin
        int n;
        repeat (3) @(negedge clk);
        chk("rst_valid", out_valid, 0);
        chk("rst_data", out_data, 0);
        chk("rst_first", out_first, 0);
        chk("rst_last", out_last, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_blk_rdy", blk_rdy, 1);
        rst_n = 1'b1;

        // Raster data = address, full-rate drain, exact latency.
        rdy_mode = 1;
        write_block(0, 12'd0, 1'b1, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("lat_valid_e1", out_valid, 0);
        @(negedge clk);
        chk("lat_valid_e2", out_valid, 1);
        chk("t1_blk_rdy", blk_rdy, 1);
        wait_drain("t1_drain");
        chk("t1_idle", out_valid, 0);

        // Random backpressure; write and done share the final cycle.
        rdy_mode = 2;
        write_block(5, 12'h7A5, 1'b0, 1'b1, 1'b1, 1'b1);
        wait_drain("t2_drain");

        // Both banks full, then overflow on a third block.
        rdy_mode = 0;
        @(posedge clk);
        #1;
        write_block(11, 12'h123, 1'b0, 1'b0, 1'b1, 1'b1);
        chk("t3_rdy_after_a", blk_rdy, 1);
        write_block(29, 12'h456, 1'b0, 1'b0, 1'b1, 1'b1);
        @(negedge clk);
        chk("t3_rdy_full", blk_rdy, 0);
        chk("t3_ovf_clear", ovf, 0);
        write_block(77, 12'h789, 1'b0, 1'b0, 1'b1, 1'b0);
        @(negedge clk);
        chk("t3_ovf_set", ovf, 1);
        rdy_mode = 1;
        wait_drain("t3_drain");
        chk("t3_rdy_back", blk_rdy, 1);
        chk("t3_ovf_sticky", ovf, 1);

        // Done lands on the same edge as the other bank's last accept.
        rdy_mode = 3;
        out_ready = 1'b0;
        write_block(3, 12'h0F0, 1'b0, 1'b0, 1'b1, 1'b1);
        write_block(41, 12'h00F, 1'b0, 1'b0, 1'b0, 1'b0);
        out_ready = 1'b1;
        n = 0;
        while (!(out_valid && out_last) && n < 300) begin
            @(negedge clk);
            n++;
        end
        chk("t4_last_seen", out_valid && out_last, 1);
        push_block();
        dct_done = 1'b1;
        @(posedge clk);
        #1;
        dct_done = 1'b0;
        @(negedge clk);
        chk("t4_gap_valid", out_valid, 0);
        chk("t4_blk_rdy", blk_rdy, 1);
        rdy_mode = 1;
        wait_drain("t4_drain");

        // Async reset mid-stream.
        beats = 0;
        write_block(17, 12'h321, 1'b0, 1'b0, 1'b1, 1'b1);
        n = 0;
        while (beats < 30 && n < 500) begin
            @(negedge clk);
            n++;
        end
        chk("t5_beats", beats, 30);
        rst_n = 1'b0;
        #1;
        chk("t5_valid", out_valid, 0);
        chk("t5_data", out_data, 0);
        chk("t5_first", out_first, 0);
        chk("t5_last", out_last, 0);
        chk("t5_ovf", ovf, 0);
        chk("t5_blk_rdy", blk_rdy, 1);
        sb.delete();
        prev_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        write_block(23, 12'h654, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("t5_drain");

        // Synchronous init while a block is stalled.
        rdy_mode = 0;
        write_block(31, 12'h111, 1'b0, 1'b0, 1'b1, 1'b1);
        repeat (3) @(negedge clk);
        chk("t6_pre_valid", out_valid, 1);
        @(posedge clk);
        #1;
        init_n = 1'b0;
        @(negedge clk);
        chk("t6_hold_valid", out_valid, 1);
        @(posedge clk);
        #1;
        init_n = 1'b1;
        sb.delete();
        prev_model = '0;
        @(negedge clk);
        chk("t6_valid", out_valid, 0);
        chk("t6_data", out_data, 0);
        chk("t6_blk_rdy", blk_rdy, 1);
        rdy_mode = 1;
        write_block(47, 12'h222, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("t6_drain");

        // DC sequence 100, 90, -5 (differences under the option).
        rst_n = 1'b0;
        #1;
        prev_model = '0;
        @(negedge clk);
        rst_n = 1'b1;
        rdy_mode = 2;
        write_block(53, 12'd100, 1'b0, 1'b0, 1'b1, 1'b1);
        write_block(59, 12'd90, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("t7_drain_ab");
        write_block(61, 12'hFFB, 1'b0, 1'b0, 1'b1, 1'b1);
        wait_drain("t7_drain_c");

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog obs=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/dct_zigzag_buf.md
Name: dct_zigzag_buf

Overview:
- Downstream stage of the 2-D forward DCT. Captures the 64 coefficients the DCT writes through its raster-addressed write port (dct_wr_add / dct_wr_data / dct_wr_n).
- On the DCT done pulse, the captured block is queued. The block is then streamed out in JPEG zigzag order on a valid/ready interface toward the quantiser/entropy coder.
- Two-bank ping-pong storage lets the DCT fill block N+1 while block N drains.

Parameters:
- cw, 12, coefficient width in bits. Equals bpp + n/2 for the forward DCT with bpp=8, n=8.
- aw, 6, address width. Fixed at log2(64); the block supports only 8x8 blocks.

Ports:
- clk  in  1  clock, all state on rising edge
- rst_n  in  1  asynchronous active-low reset
- init_n  in  1  synchronous active-low clear; same effect as reset, takes effect at the next edge
- dct_wr_n  in  1  active-low coefficient write strobe from the DCT
- dct_wr_add  in  aw  raster address of the coefficient (row*8+col)
- dct_wr_data  in  cw  coefficient, two's complement
- dct_done  in  1  one-cycle pulse: the current write bank is complete
- blk_rdy  out  1  high when the current write bank is free; DCT start is gated by it
- out_data  out  cw  coefficient in zigzag order
- out_valid  out  1  out_data valid
- out_ready  in  1  downstream accept
- out_first  out  1  high with zigzag index 0 (DC)
- out_last  out  1  high with zigzag index 63
- ovf  out  1  sticky: a write or done arrived while the write bank was full

Behaviour:
Storage and write side
- Storage: mem[2][64] of cw bits. Control state: wr_bank, rd_bank, full[1:0], FSM, 6-bit index k.
- Reset / init_n clears:
  - wr_bank = rd_bank = 0, full = 0, FSM = IDLE, k = 0.
  - out_valid = out_first = out_last = 0, out_data = 0, ovf = 0.
  - blk_rdy = 1.
  - Memory contents are not cleared.
- blk_rdy = ~full[wr_bank] (combinational).
- Write: when dct_wr_n == 0 and full[wr_bank] == 0, set mem[wr_bank][dct_wr_add] <= dct_wr_data. If full[wr_bank] == 1, drop the write and set ovf.
- Done: when dct_done and ~full[wr_bank], set full[wr_bank] and toggle wr_bank. If full[wr_bank], ignore the done and set ovf.
- A write and a done in the same cycle: the write lands in the bank being closed.

Read FSM
- IDLE: if full[rd_bank], load out_data <= mem[rd_bank][zz(0)], out_valid = 1, out_first = 1, k = 1, go to STREAM.
- STREAM, on out_valid & out_ready:
  - If out_last is not set: load mem[rd_bank][zz(k)] into out_data, k++, out_last = (k == 63). There is no bubble between elements.
  - If out_last is set: out_valid = 0, full[rd_bank] = 0, toggle rd_bank, go to IDLE.
- Without a handshake, out_data, out_first and out_last hold stable. out_first clears on the first accept.
- Latency: out_valid rises 2 clocks after the edge that samples dct_done: full is set at edge 1, the output is loaded at edge 2. There is at least one idle cycle between blocks.
- The full clear by the reader and the full set by the writer can occur in the same cycle on different banks; both take effect.
- The bank being streamed is never writable: it is full until its last transfer.
- zz(k) is a combinational 64-entry ROM of the standard JPEG zigzag. It begins 0,1,8,16,9,2,3,10,17,24,32,25,18,11,4,5 and ends 61,54,47,55,62,63.
- Reset or init_n mid-stream: the block is abandoned, out_valid drops immediately (async for rst_n, next edge for init_n), and both banks are marked empty.

Optional Feature:
- Macro DCT_ZZ_DC_DIFF_EN.
- Defined:
  - The block holds a cw-bit register prev_dc, reset/init to 0.
  - For index 0, out_data = mem DC - prev_dc, modulo 2^cw (wraps, no saturation).
  - prev_dc updates to the raw DC when element 0 is accepted.
  - AC coefficients pass unchanged.
- Undefined: out_data is always the raw stored coefficient and prev_dc does not exist.

Test Plan:
- Raster write with data = address (0..63), then done, out_ready = 1 -> out_valid rises 2 cycles after done, 64 consecutive beats of data 0,1,8,16,9,2,...,62,63; out_first on beat 0, out_last on beat 63; blk_rdy stays 1.
- out_ready toggled randomly (50%) -> same sequence; out_data stable while out_valid & ~out_ready.
- Two blocks back-to-back, out_ready held 0 -> blk_rdy drops after the second done; a third write and third done set ovf = 1. Release out_ready -> blocks stream in order and blk_rdy returns to 1 after block 1's last beat.
- dct_done in the same cycle as the last accept of the other bank -> both banks are handled correctly, with no lost or duplicated block.
- rst_n asserted at beat 30 -> all outputs are 0 and blk_rdy = 1 immediately; the next block streams from beat 0.
- With DCT_ZZ_DC_DIFF_EN: DC values 100, 90, -5 in three blocks -> first beats are 100, -10, -95; AC beats are unchanged.
